// File: rtl/uart_cmd_responder.sv
// -----------------------------------------------------------------------------
// uart_cmd_responder
//
// Target-side command engine for the host UART link. Collects a command frame
// {opcode, address, data} MSB first from the UART receiver byte stream, runs it
// against an internal word memory and returns a response frame
// {response opcode, address, data} through the UART transmitter handshake.
//
// Ports:
//   CLOCK     in   system clock, rising edge
//   NRESET    in   synchronous reset, active-high
//   RXDATA    in   received byte, valid with RXDONE
//   RXDONE    in   one-cycle pulse per received byte
//   TXDATA    out  byte to transmit, valid with TXSTART
//   TXSTART   out  one-cycle transmit request
//   TXDONE    in   one-cycle pulse when the transmitter finishes a byte
//   BUSY      out  high from frame completion until the last response TXDONE
//   FRAMEERR  out  one-cycle pulse when a partial frame is dropped on timeout
//   OVERRUN   out  one-cycle pulse when a byte arrives while BUSY (byte dropped)
// -----------------------------------------------------------------------------
module uart_cmd_responder #(
    parameter int unsigned OPCDBYTE = 2,
    parameter int unsigned ADDRBYTE = 2,
    parameter int unsigned DATABYTE = 4,
    parameter int unsigned DEPTH    = 256,
    parameter int unsigned TIMEOUT  = 8680
) (
    input  logic       CLOCK,
    input  logic       NRESET,
    input  logic [7:0] RXDATA,
    input  logic       RXDONE,
    output logic [7:0] TXDATA,
    output logic       TXSTART,
    input  logic       TXDONE,
    output logic       BUSY,
    output logic       FRAMEERR,
    output logic       OVERRUN
);

    localparam int unsigned Frame  = OPCDBYTE + ADDRBYTE + DATABYTE;
    localparam int unsigned FrameW = Frame * 8;
    localparam int unsigned OpW    = OPCDBYTE * 8;
    localparam int unsigned AddrW  = ADDRBYTE * 8;
    localparam int unsigned DataW  = DATABYTE * 8;
    localparam int unsigned MemAw  = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int unsigned CntW   = $clog2(Frame + 1);
    localparam int unsigned IdleW  = $clog2(TIMEOUT + 1);

    localparam logic [OpW-1:0] OpWrite  = OpW'(1);
    localparam logic [OpW-1:0] OpRead   = OpW'(2);
    localparam logic [OpW-1:0] OpPing   = OpW'(3);
    // Responses echo the opcode with the top bit set; errors report 0xFF.
    localparam logic [OpW-1:0] RspFlag  = {1'b1, {(OpW-1){1'b0}}};
    localparam logic [OpW-1:0] RspWrite = RspFlag | OpWrite;
    localparam logic [OpW-1:0] RspRead  = RspFlag | OpRead;
    localparam logic [OpW-1:0] RspPing  = RspFlag | OpPing;
    localparam logic [OpW-1:0] RspError = RspFlag | OpW'(8'hFF);

    localparam logic [CntW-1:0]  RxLast   = CntW'(Frame - 1);
    localparam logic [CntW-1:0]  TxAll    = CntW'(Frame);
    localparam logic [IdleW-1:0] IdleLast = IdleW'(TIMEOUT - 1);

    typedef enum logic [2:0] {
        StRecv,
        StExec,
        StLoad,
        StSend,
        StWait
    } state_e;

    state_e            state_q;
    logic [CntW-1:0]   rxcnt_q;
    logic [CntW-1:0]   txcnt_q;
    logic [IdleW-1:0]  idle_q;
    logic [FrameW-1:0] frame_q;
    logic [FrameW-1:0] resp_q;
    logic [7:0]        txdata_q;
    logic              txstart_q;
    logic              busy_q;
    logic              frameerr_q;
    logic              overrun_q;

    logic [DataW-1:0]  mem_q [DEPTH];

    // Command decode
    logic [OpW-1:0]    cmd_op;
    logic [AddrW-1:0]  cmd_addr;
    logic [DataW-1:0]  cmd_data;
    logic              addr_ok;
    logic [MemAw-1:0]  mem_idx;
    logic [OpW-1:0]    rsp_op;
    logic [DataW-1:0]  rsp_data;
    logic              mem_we;
    logic [FrameW-1:0] resp_w;
    logic              timeout_hit;

    assign cmd_op   = frame_q[FrameW-1 -: OpW];
    assign cmd_addr = frame_q[DataW +: AddrW];
    assign cmd_data = frame_q[DataW-1:0];
    assign addr_ok  = (32'(cmd_addr) < DEPTH);
    assign mem_idx  = cmd_addr[MemAw-1:0];

    always_comb begin
        rsp_op   = RspError;
        rsp_data = '0;
        mem_we   = 1'b0;
        case (cmd_op)
            OpWrite: begin
                if (addr_ok) begin
                    rsp_op   = RspWrite;
                    rsp_data = cmd_data;
                    mem_we   = (state_q == StExec) && !NRESET;
                end
            end
            OpRead: begin
                if (addr_ok) begin
                    rsp_op   = RspRead;
                    rsp_data = mem_q[mem_idx];
                end
            end
            OpPing: begin
                rsp_op   = RspPing;
                rsp_data = cmd_data;
            end
            default: ;
        endcase
        resp_w = {rsp_op, cmd_addr, rsp_data};
    end

    // Memory has no reset; only EXEC of an in-range WRITE touches it.
    always_ff @(posedge CLOCK) begin
        if (mem_we) begin
            mem_q[mem_idx] <= cmd_data;
        end
    end

    // A partial frame expires once the idle count reaches TIMEOUT; an empty
    // receiver never expires.
    assign timeout_hit = (rxcnt_q != '0) && (idle_q == IdleLast);

    // Control FSM. TXSTART/TXDATA are registered on the transition into LOAD,
    // so the pulse is visible for exactly the one cycle spent in LOAD.
    always_ff @(posedge CLOCK) begin
        if (NRESET) begin
            state_q    <= StRecv;
            rxcnt_q    <= '0;
            txcnt_q    <= '0;
            idle_q     <= '0;
            frame_q    <= '0;
            resp_q     <= '0;
            txdata_q   <= 8'h00;
            txstart_q  <= 1'b0;
            busy_q     <= 1'b0;
            frameerr_q <= 1'b0;
            overrun_q  <= 1'b0;
        end else begin
            txstart_q  <= 1'b0;
            frameerr_q <= 1'b0;
            overrun_q  <= RXDONE && busy_q;

            unique case (state_q)
                StRecv: begin
                    if (timeout_hit) begin
                        // Timeout wins over a byte arriving on the same cycle.
                        rxcnt_q    <= '0;
                        idle_q     <= '0;
                        frameerr_q <= 1'b1;
                    end else if (RXDONE) begin
                        frame_q <= {frame_q[FrameW-9:0], RXDATA};
                        idle_q  <= '0;
                        if (rxcnt_q == RxLast) begin
                            rxcnt_q <= '0;
                            busy_q  <= 1'b1;
                            state_q <= StExec;
                        end else begin
                            rxcnt_q <= rxcnt_q + CntW'(1);
                        end
                    end else if (rxcnt_q != '0) begin
                        idle_q <= idle_q + IdleW'(1);
                    end
                end

                StExec: begin
                    txdata_q  <= resp_w[FrameW-1 -: 8];
                    resp_q    <= {resp_w[FrameW-9:0], 8'h00};
                    txcnt_q   <= CntW'(1);
                    txstart_q <= 1'b1;
                    state_q   <= StLoad;
                end

                StLoad: begin
                    state_q <= StSend;
                end

                StSend: begin
                    if (TXDONE) begin
                        if (txcnt_q == TxAll) begin
                            txcnt_q <= '0;
                            busy_q  <= 1'b0;
                            state_q <= StRecv;
                        end else begin
                            state_q <= StWait;
                        end
                    end
                end

                StWait: begin
                    txdata_q  <= resp_q[FrameW-1 -: 8];
                    resp_q    <= {resp_q[FrameW-9:0], 8'h00};
                    txcnt_q   <= txcnt_q + CntW'(1);
                    txstart_q <= 1'b1;
                    state_q   <= StLoad;
                end

                default: begin
                    state_q <= StRecv;
                end
            endcase
        end
    end

    assign TXDATA   = txdata_q;
    assign TXSTART  = txstart_q;
    assign BUSY     = busy_q;
    assign FRAMEERR = frameerr_q;
    assign OVERRUN  = overrun_q;

endmodule

// File: tb/tb_uart_cmd_responder.sv
// -----------------------------------------------------------------------------
// tb_uart_cmd_responder
//
// Directed bench for uart_cmd_responder. A frame-level model (byte queues and
// an associative memory) predicts every TXSTART/TXDATA, BUSY, FRAMEERR and
// OVERRUN value each cycle; literal response words pin the model per test.
// -----------------------------------------------------------------------------
module tb_uart_cmd_responder;

    localparam int unsigned TIMEOUT = 8680;
    localparam int          FBYTES  = 8;

    logic       CLOCK  = 1'b0;
    logic       NRESET = 1'b1;
    logic [7:0] RXDATA = 8'h00;
    logic       RXDONE = 1'b0;
    logic       TXDONE = 1'b0;
    logic [7:0] TXDATA;
    logic       TXSTART;
    logic       BUSY;
    logic       FRAMEERR;
    logic       OVERRUN;

    uart_cmd_responder #(
        .OPCDBYTE(2),
        .ADDRBYTE(2),
        .DATABYTE(4),
        .DEPTH   (256),
        .TIMEOUT (TIMEOUT)
    ) dut (
        .CLOCK   (CLOCK),
        .NRESET  (NRESET),
        .RXDATA  (RXDATA),
        .RXDONE  (RXDONE),
        .TXDATA  (TXDATA),
        .TXSTART (TXSTART),
        .TXDONE  (TXDONE),
        .BUSY    (BUSY),
        .FRAMEERR(FRAMEERR),
        .OVERRUN (OVERRUN)
    );

    always #5 CLOCK = ~CLOCK;

    int n_checks = 0;
    int n_fail   = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // ---------------- frame-level model ----------------
    logic [31:0] mm [int];
    logic [7:0]  held_q[$];
    logic [7:0]  exp_q[$];
    logic [7:0]  cap_q[$];
    int          cyc        = 0;
    int          last_acc   = 0;
    int          next_start = -1;
    int          await_from = 0;
    bit          m_busy     = 0;
    bit          m_await    = 0;
    bit          started    = 0;
    int          fe_count   = 0;
    int          ov_count   = 0;
    int          start_count = 0;
    logic        start_exp, fe_exp, ov_exp;

    function automatic void execute(input logic [63:0] fr);
        logic [15:0] op;
        logic [15:0] addr;
        logic [31:0] d;
        logic [15:0] rop;
        logic [31:0] rd;
        logic [63:0] rsp;
        op   = fr[63:48];
        addr = fr[47:32];
        d    = fr[31:0];
        rop  = 16'h80FF;
        rd   = 32'h0;
        if (op == 16'h0001 && addr < 16'd256) begin
            mm[int'(addr)] = d;
            rop = 16'h8001;
            rd  = d;
        end else if (op == 16'h0002 && addr < 16'd256) begin
            rop = 16'h8002;
            rd  = mm.exists(int'(addr)) ? mm[int'(addr)] : 32'hxxxx_xxxx;
        end else if (op == 16'h0003) begin
            rop = 16'h8003;
            rd  = d;
        end
        rsp = {rop, addr, rd};
        for (int i = 0; i < FBYTES; i++) exp_q.push_back(rsp[63-8*i -: 8]);
    endfunction

    // Compare process: sample 1 time unit after each rising edge; inputs seen
    // here are the ones that edge sampled.
    initial begin
        logic [63:0] fr;
        forever begin
            @(posedge CLOCK);
            #1;
            cyc++;
            if (NRESET) begin
                started    = 1;
                held_q.delete();
                exp_q.delete();
                m_busy     = 0;
                m_await    = 0;
                next_start = -1;
                chk("rst_txstart", TXSTART, 0);
                chk("rst_txdata", TXDATA, 0);
                chk("rst_busy", BUSY, 0);
                chk("rst_frameerr", FRAMEERR, 0);
                chk("rst_overrun", OVERRUN, 0);
            end else if (started) begin
                start_exp = (next_start == cyc);
                fe_exp    = 1'b0;
                ov_exp    = RXDONE && m_busy;
                if (start_exp) begin
                    m_await    = 1;
                    await_from = cyc + 2;
                    next_start = -1;
                end
                if (!m_busy) begin
                    if (held_q.size() > 0 && cyc - last_acc == int'(TIMEOUT)) begin
                        held_q.delete();
                        fe_exp = 1'b1;
                    end else if (RXDONE) begin
                        held_q.push_back(RXDATA);
                        last_acc = cyc;
                        if (held_q.size() == FBYTES) begin
                            fr = '0;
                            for (int i = 0; i < FBYTES; i++) fr = {fr[55:0], held_q[i]};
                            held_q.delete();
                            execute(fr);
                            m_busy     = 1;
                            next_start = cyc + 1;
                        end
                    end
                end else if (m_await && TXDONE && cyc >= await_from) begin
                    m_await = 0;
                    if (exp_q.size() == 0 && !start_exp) m_busy = 0;
                    else next_start = cyc + 1;
                end
                chk("txstart", TXSTART, start_exp);
                if (TXSTART && start_exp && exp_q.size() > 0)
                    chk("txdata", TXDATA, exp_q.pop_front());
                chk("busy", BUSY, m_busy);
                chk("frameerr", FRAMEERR, fe_exp);
                chk("overrun", OVERRUN, ov_exp);
                if (TXSTART) begin
                    cap_q.push_back(TXDATA);
                    start_count++;
                end
                if (FRAMEERR) fe_count++;
                if (OVERRUN) ov_count++;
            end
        end
    end

    // Transmitter stand-in: TXDONE a few cycles after each TXSTART.
    initial begin
        forever begin
            @(posedge CLOCK);
            #1;
            if (TXSTART) begin
                repeat (3) @(negedge CLOCK);
                TXDONE = 1'b1;
                @(negedge CLOCK);
                TXDONE = 1'b0;
            end
        end
    end

    // ---------------- stimulus helpers ----------------
    task automatic send_byte(input logic [7:0] b, input int gap);
        @(negedge CLOCK);
        RXDATA = b;
        RXDONE = 1'b1;
        @(negedge CLOCK);
        RXDONE = 1'b0;
        repeat (gap) @(negedge CLOCK);
    endtask

    task automatic send_frame(input logic [63:0] f);
        for (int i = 0; i < FBYTES; i++) send_byte(f[63-8*i -: 8], 1);
    endtask

    task automatic wait_idle(input string name);
        int k;
        for (k = 0; k < 400; k++) begin
            @(negedge CLOCK);
            if (!BUSY) break;
        end
        chk({name, "_idle_in_time"}, (k < 400), 1);
        repeat (4) @(negedge CLOCK);
    endtask

    task automatic wait_bytes(input string name, input int n);
        int k;
        for (k = 0; k < 400; k++) begin
            @(negedge CLOCK);
            if (cap_q.size() >= n) break;
        end
        chk({name, "_bytes_in_time"}, (k < 400), 1);
    endtask

    task automatic check_resp(input string name, input logic [63:0] exp);
        logic [63:0] got;
        got = '0;
        chk({name, "_len"}, cap_q.size(), FBYTES);
        for (int i = 0; i < FBYTES && i < cap_q.size(); i++) got = {got[55:0], cap_q[i]};
        chk(name, got, exp);
        cap_q.delete();
    endtask

    // ---------------- directed sequence ----------------
    initial begin
        int fe0, ov0, s0;
        repeat (3) @(negedge CLOCK);
        NRESET = 1'b0;
        @(negedge CLOCK);
        chk("init_txdata", TXDATA, 8'h00);
        chk("init_busy", BUSY, 0);

        send_frame(64'h0001_0010_DEADBEEF);
        wait_idle("wr");
        check_resp("wr_resp", 64'h8001_0010_DEADBEEF);
        chk("wr_busy_low", BUSY, 0);

        send_frame(64'h0002_0010_00000000);
        wait_idle("rd");
        check_resp("rd_resp", 64'h8002_0010_DEADBEEF);

        send_frame(64'h0001_0000_11111111);
        wait_idle("wr0");
        check_resp("wr0_resp", 64'h8001_0000_11111111);

        send_frame(64'h0001_00FF_A5A5A5A5);
        wait_idle("wrtop");
        check_resp("wrtop_resp", 64'h8001_00FF_A5A5A5A5);

        send_frame(64'h0002_0100_00000000);
        wait_idle("rd_oor");
        check_resp("rd_oor_resp", 64'h80FF_0100_00000000);

        send_frame(64'h0001_0100_CAFEF00D);
        wait_idle("wr_oor");
        check_resp("wr_oor_resp", 64'h80FF_0100_00000000);

        send_frame(64'h1234_0020_11112222);
        wait_idle("badop");
        check_resp("badop_resp", 64'h80FF_0020_00000000);

        send_frame(64'h0002_0000_00000000);
        wait_idle("rd0");
        check_resp("rd0_unchanged", 64'h8002_0000_11111111);

        send_frame(64'h0002_00FF_00000000);
        wait_idle("rdtop");
        check_resp("rdtop_resp", 64'h8002_00FF_A5A5A5A5);

        // Partial frame expires.
        fe0 = fe_count;
        s0  = start_count;
        send_byte(8'h00, 1);
        send_byte(8'h03, 1);
        send_byte(8'hAB, 1);
        repeat (TIMEOUT + 20) @(negedge CLOCK);
        chk("to_frameerr_once", fe_count - fe0, 1);
        chk("to_no_txstart", start_count - s0, 0);
        send_frame(64'h0003_ABCD_01234567);
        wait_idle("ping");
        check_resp("ping_resp", 64'h8003_ABCD_01234567);

        // Byte arriving on the exact timeout cycle is dropped.
        fe0 = fe_count;
        s0  = start_count;
        send_byte(8'h00, 0);
        repeat (TIMEOUT - 2) @(negedge CLOCK);
        send_byte(8'h77, 20);
        chk("to_race_frameerr", fe_count - fe0, 1);
        chk("to_race_no_txstart", start_count - s0, 0);
        send_frame(64'h0003_0102_0A0B0C0D);
        wait_idle("ping2");
        check_resp("ping2_resp", 64'h8003_0102_0A0B0C0D);

        // Byte during a response: overrun, response intact.
        ov0 = ov_count;
        send_frame(64'h0002_0010_00000000);
        wait_bytes("ovr", 2);
        send_byte(8'h55, 0);
        wait_idle("ovr");
        chk("ovr_pulse_once", ov_count - ov0, 1);
        check_resp("ovr_resp", 64'h8002_0010_DEADBEEF);
        send_frame(64'h0003_0001_89ABCDEF);
        wait_idle("ovr_next");
        check_resp("ovr_next_resp", 64'h8003_0001_89ABCDEF);

        // Reset during the 4th response byte.
        send_frame(64'h0001_0020_12345678);
        wait_bytes("mrst", 4);
        @(negedge CLOCK);
        NRESET = 1'b1;
        repeat (2) @(negedge CLOCK);
        NRESET = 1'b0;
        s0 = start_count;
        repeat (40) @(negedge CLOCK);
        chk("mrst_no_txstart", start_count - s0, 0);
        chk("mrst_busy_low", BUSY, 0);
        cap_q.delete();
        send_frame(64'h0002_0020_00000000);
        wait_idle("mrst_next");
        check_resp("mrst_next_resp", 64'h8002_0020_12345678);

        repeat (5) @(negedge CLOCK);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not complete, got timeout expected finish");
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/uart_cmd_responder.md
# uart_cmd_responder

Target-side command engine for the host UART link. It collects the 8-byte command frame {opcode(2), address(2), data(4)}, MSB first, from the UART receiver's byte stream. It executes the command against an internal word memory and returns an 8-byte response frame through the UART transmitter byte handshake. It sits between the UART RX/TX byte ports and stands in for the host-side frame source/sink pair.

## Interface
Parameters:
- OPCDBYTE, 2, opcode bytes per frame
- ADDRBYTE, 2, address bytes per frame
- DATABYTE, 4, data bytes per frame (memory word = DATABYTE*8 bits)
- DEPTH, 256, memory words; valid addresses 0..DEPTH-1
- TIMEOUT, 8680, inter-byte idle cycles before a partial frame is discarded (2 byte times at 50 MHz / 115200)

Ports:
- CLOCK  in  1  single system clock, rising edge
- NRESET  in  1  reset, synchronous, active-high
- RXDATA  in  8  received byte, valid when RXDONE=1
- RXDONE  in  1  one-cycle pulse per received byte
- TXDATA  out  8  byte to transmit, valid when TXSTART=1
- TXSTART  out  1  one-cycle pulse requesting transmission of TXDATA
- TXDONE  in  1  one-cycle pulse when the transmitter finishes a byte
- BUSY  out  1  high from frame completion until the last response byte's TXDONE
- FRAMEERR  out  1  one-cycle pulse when a partial frame is discarded on timeout
- OVERRUN  out  1  one-cycle pulse when RXDONE arrives while BUSY=1 (byte dropped)

## Operation
- Frame length F = OPCDBYTE+ADDRBYTE+DATABYTE = 8. Bytes are shifted into a frame register MSB first. A byte counter runs 0..F-1.
- States: RECV, EXEC, LOAD, SEND, WAIT.
- RECV: each RXDONE stores a byte and increments the counter. When the F-th byte is stored, the counter clears, BUSY rises and the FSM moves to EXEC.
- EXEC (1 cycle): decode opcode and build the response register {rop, addr, rdata}:
  - 16'h0001 WRITE: if addr<DEPTH, write mem[addr]=data; rop=16'h8001; rdata=data.
  - 16'h0002 READ: if addr<DEPTH, rdata=mem[addr]; rop=16'h8002.
  - 16'h0003 PING: no memory access; rop=16'h8003; rdata=data.
  - Any other opcode, or addr>=DEPTH on WRITE/READ: no write; rop=16'h80FF; rdata=32'h0.
  - addr is echoed unchanged in every response.
- LOAD: drive TXDATA with the next response byte, MSB first, and pulse TXSTART for one cycle. Then go to SEND.
- SEND: wait for TXDONE. On TXDONE, if bytes remain go to WAIT, otherwise clear BUSY and go to RECV.
- WAIT (1 cycle): guard gap, then go to LOAD.
- Timeout: the idle counter clears on every RXDONE and counts only in RECV with 1..F-1 bytes held. On reaching TIMEOUT, the partial frame is discarded, the counter returns to 0 and FRAMEERR pulses. An empty RECV never times out.
- RXDONE while BUSY=1: the byte is ignored and OVERRUN pulses. The frame counter is unaffected.
- RXDONE on the same cycle the timeout fires: timeout wins, the byte is dropped and FRAMEERR pulses.
- TXDONE outside SEND is ignored.
- Memory is not reset. Reads of never-written words return undefined data.

## Timing
- Reset values: TXDATA=8'h00, TXSTART=0, BUSY=0, FRAMEERR=0, OVERRUN=0. FSM=RECV, byte counter=0, idle counter=0.
- Reset asserted mid-frame or mid-response aborts immediately. TXSTART is 0 from the next edge, and no further bytes are issued after reset deasserts.
- Last command byte's RXDONE at edge N gives BUSY=1 at N+1, EXEC at N+1, and the first TXSTART at N+2.
- Each subsequent TXSTART occurs 2 cycles after the preceding TXDONE.
- BUSY falls on the edge after the 8th TXDONE.
- WRITE is visible to a READ in the immediately following frame.
- FRAMEERR is asserted TIMEOUT cycles after the last accepted byte.

## Test plan
- WRITE op=0001 addr=0010 data=DEADBEEF -> response bytes 80 01 00 10 DE AD BE EF in order, one TXSTART per TXDONE, BUSY low afterwards.
- READ op=0002 addr=0010 after the above -> 80 02 00 10 DE AD BE EF. First TXSTART 2 cycles after the 8th RXDONE.
- READ addr=0100 (DEPTH=256) and opcode 0x1234 -> 80 FF 01 00 00 00 00 00 and 80 FF addr 00 00 00 00; a subsequent READ confirms memory is unchanged.
- Send 3 bytes, then idle TIMEOUT cycles -> FRAMEERR pulse exactly once, no TXSTART. A following full PING 0003/ABCD/01234567 -> 80 03 AB CD 01 23 45 67.
- Inject RXDONE during a response -> OVERRUN pulse, response unaltered, next frame decoded correctly.
- Assert NRESET during the 4th response byte -> outputs at reset values, no TXSTART afterwards, next full frame handled normally.
